// File: rtl/jtkicker_romarb_pkg.sv
// rtl/jtkicker_romarb_pkg.sv - shared types and constants for the two-client ROM arbiter
// Contents:
//   state_t        arbiter FSM encoding (IDLE, ISSUE, WAIT)
//   CL_SCR/CL_OBJ  client index constants
//   AW_*           address widths of the shared ROM port and of each client
//   rom_word()     region offset plus zero-extended client word address, modulo 2^AW_ROM
package jtkicker_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int CL_SCR = 0;
    localparam int CL_OBJ = 1;

    localparam int AW_ROM = 15;
    localparam int AW_SCR = 13;
    localparam int AW_OBJ = 14;

    // Wraps silently: an offset near the top of the ROM space folds back to 0.
    function automatic logic [AW_ROM-1:0] rom_word(input logic [AW_ROM-1:0] offset,
                                                   input logic [AW_OBJ-1:0] addr);
        return offset + {{(AW_ROM-AW_OBJ){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/jtkicker_romarb_slot.sv
// rtl/jtkicker_romarb_slot.sv - one-entry fetch cache for a single ROM client
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cs, addr              live client request and word address
//   load                  one-cycle strobe from the arbiter: fetch for this client finished
//   load_addr, load_data  address captured at grant and word returned by the SDRAM
//   data                  cached word
//   ok                    cached word belongs to the current addr and the client is requesting
//   pending               client is requesting something not in the cache
module jtkicker_romarb_slot
    import jtkicker_romarb_pkg::*;
#(
    parameter int AW = AW_SCR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   data,
    output logic          ok,
    output logic          pending
);

    logic [AW-1:0] last_addr;
    logic          valid;
    logic          hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
            valid     <= 1'b0;
            data      <= '0;
        end else if (load) begin
            // Stored under the address seen at grant, so a mid-fetch address
            // change leaves hit low and the client fetches again.
            last_addr <= load_addr;
            valid     <= 1'b1;
            data      <= load_data;
        end
    end

    // Combinational against the live addr: ok falls in the same cycle addr moves.
    assign hit     = valid && (addr == last_addr);
    assign ok      = cs && hit;
    assign pending = cs && !hit;

endmodule

// File: rtl/jtkicker_romarb.sv
// rtl/jtkicker_romarb.sv - scroll/object arbiter sharing one 32-bit SDRAM ROM port
// Ports:
//   clk, rst_n                 48 MHz clock, asynchronous active-low reset
//   scr_cs, scr_addr           scroll tile fetcher request (level) and word address
//   scr_data, scr_ok           scroll fetched word and its valid flag
//   obj_cs, obj_addr           object fetcher request (level) and word address
//   obj_data, obj_ok           object fetched word and its valid flag
//   rom_cs, rom_addr           SDRAM request and word address, held until rom_ok
//   rom_data, rom_ok           SDRAM returned word and its valid strobe
//   busy                       FSM is not in IDLE
module jtkicker_romarb
    import jtkicker_romarb_pkg::*;
#(
    parameter logic [14:0] SCR_OFFSET = 15'h0000,
    parameter logic [14:0] OBJ_OFFSET = 15'h2000,
    parameter int          STARVE     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scr_cs,
    input  logic [AW_SCR-1:0] scr_addr,
    output logic [31:0]       scr_data,
    output logic              scr_ok,
    input  logic              obj_cs,
    input  logic [AW_OBJ-1:0] obj_addr,
    output logic [31:0]       obj_data,
    output logic              obj_ok,
    output logic              rom_cs,
    output logic [AW_ROM-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              rom_ok,
    output logic              busy
);

    state_t            state, state_nx;
    logic              scr_pend, obj_pend;
    logic              start, done, pick_obj;
    logic              gnt;
    logic [AW_OBJ-1:0] cap_addr;
    logic [3:0]        starve_cnt;

    jtkicker_romarb_slot #(.AW(AW_SCR)) u_scr (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (scr_cs),
        .addr      (scr_addr),
        .load      (done && (gnt == 1'(CL_SCR))),
        .load_addr (cap_addr[AW_SCR-1:0]),
        .load_data (rom_data),
        .data      (scr_data),
        .ok        (scr_ok),
        .pending   (scr_pend)
    );

    jtkicker_romarb_slot #(.AW(AW_OBJ)) u_obj (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (obj_cs),
        .addr      (obj_addr),
        .load      (done && (gnt == 1'(CL_OBJ))),
        .load_addr (cap_addr),
        .load_data (rom_data),
        .data      (obj_data),
        .ok        (obj_ok),
        .pending   (obj_pend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
        pick_obj = 1'b0;
        case (state)
            IDLE: begin
                if (scr_pend || obj_pend) begin
                    start    = 1'b1;
                    // Scroll wins ties unless the object side has been passed over STARVE times.
                    pick_obj = obj_pend && (!scr_pend || starve_cnt == 4'(STARVE));
                    state_nx = ISSUE;
                end
            end
            // rom_ok here may still belong to the previous address, so it is not looked at.
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (rom_ok) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            gnt        <= 1'(CL_SCR);
            cap_addr   <= '0;
            starve_cnt <= '0;
        end else begin
            if (start) begin
                rom_cs <= 1'b1;
                gnt    <= pick_obj;
                if (pick_obj) begin
                    cap_addr   <= obj_addr;
                    rom_addr   <= rom_word(OBJ_OFFSET, obj_addr);
                    starve_cnt <= '0;
                end else begin
                    cap_addr <= {1'b0, scr_addr};
                    rom_addr <= rom_word(SCR_OFFSET, {1'b0, scr_addr});
                    if (obj_pend) starve_cnt <= starve_cnt + 4'd1;
                end
            end
            if (done) rom_cs <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_jtkicker_romarb.sv
// tb/tb_jtkicker_romarb.sv - self-checking bench for jtkicker_romarb
module tb_jtkicker_romarb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scr_cs, obj_cs;
    logic [12:0] scr_addr;
    logic [13:0] obj_addr;
    logic [31:0] scr_data, obj_data, rom_data;
    logic        scr_ok, obj_ok, rom_cs, rom_ok, busy;
    logic [14:0] rom_addr;

    logic        scr_cs2, obj_cs2, rom_ok2;
    logic [12:0] scr_addr2;
    logic [13:0] obj_addr2;
    logic [31:0] scr_data2, obj_data2, rom_data2;
    logic        scr_ok2, obj_ok2, rom_cs2, busy2;
    logic [14:0] rom_addr2;

    logic        m_ok = 1'b0, f_ok, model_en;
    int          mcnt = 0;
    logic        cs_prev;
    int          issue_cnt = 0;
    logic [14:0] obs_q[$];
    logic [14:0] exp_q[$];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    assign rom_ok = m_ok | f_ok;

    jtkicker_romarb dut (
        .clk(clk), .rst_n(rst_n),
        .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .busy(busy)
    );

    jtkicker_romarb #(.OBJ_OFFSET(15'h7FF0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .scr_cs(scr_cs2), .scr_addr(scr_addr2), .scr_data(scr_data2), .scr_ok(scr_ok2),
        .obj_cs(obj_cs2), .obj_addr(obj_addr2), .obj_data(obj_data2), .obj_ok(obj_ok2),
        .rom_cs(rom_cs2), .rom_addr(rom_addr2), .rom_data(rom_data2), .rom_ok(rom_ok2),
        .busy(busy2)
    );

    function automatic logic [31:0] data_fn(input logic [14:0] a);
        if (a == 15'h0123) return 32'hDEADBEEF;
        return {17'h0A5A5, a};
    endfunction

    // SDRAM model: rom_ok rises on the second cycle rom_cs is seen high.
    always @(negedge clk) begin
        rom_data <= data_fn(rom_addr);
        if (!rom_cs || !model_en) begin
            mcnt <= 0;
            m_ok <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            m_ok <= (mcnt + 1 >= 2);
        end
    end

    // Every rising rom_cs is recorded as an issued fetch.
    always @(negedge clk) begin
        cs_prev <= rom_cs;
        if (rom_cs && !cs_prev) begin
            issue_cnt <= issue_cnt + 1;
            obs_q.push_back(rom_addr);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_issues(input string tag);
        while (exp_q.size() > 0) begin
            if (obs_q.size() == 0) begin
                chk({tag, "_missing"}, 32'h0, {17'h0, exp_q.pop_front()});
            end else begin
                chk(tag, {17'h0, obs_q.pop_front()}, {17'h0, exp_q.pop_front()});
            end
        end
        chk({tag, "_extra"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, lows, si;
        rst_n = 1'b0; f_ok = 1'b0; model_en = 1'b1;
        scr_cs = 0; scr_addr = '0; obj_cs = 0; obj_addr = '0;
        scr_cs2 = 0; scr_addr2 = '0; obj_cs2 = 0; obj_addr2 = '0;
        rom_ok2 = 0; rom_data2 = 32'h1234_5678;
        step(); step();
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", {scr_data | obj_data}, 0);
        chk("rst_ok", {scr_ok, obj_ok}, 0);
        chk("rst_dut2", {scr_data2 | obj_data2}, {31'h0, scr_ok2 | obj_ok2 | busy2 | rom_cs2});
        rst_n = 1'b1;
        step();

        // Single scroll fetch with latency measurement
        scr_addr = 13'h0123; scr_cs = 1; exp_q.push_back(15'h0123);
        n = 0;
        while (!scr_ok && n < 20) begin step(); n++; end
        chk("scr_latency", n, 3);
        chk("scr_data", scr_data, 32'hDEADBEEF);
        check_issues("scr_rom_addr");

        // Cache hit: no further fetches, ok stays high
        base = issue_cnt; lows = 0;
        for (int i = 0; i < 20; i++) begin step(); if (!scr_ok) lows++; end
        chk("hit_no_refetch", issue_cnt, base);
        chk("hit_ok_lows", lows, 0);
        scr_addr = 13'h0124; #1;
        chk("ok_drop_same_cycle", scr_ok, 0);
        scr_cs = 0; scr_addr = 13'h0123;
        step();
        scr_cs = 1; #1;
        chk("ok_back_on_hit", scr_ok, 1);
        scr_cs = 0;
        step();

        // Object offset
        obj_addr = 14'h0010; obj_cs = 1; exp_q.push_back(15'h2010);
        n = 0;
        while (!obj_ok && n < 20) begin step(); n++; end
        chk("obj_data", obj_data, data_fn(15'h2010));
        check_issues("obj_rom_addr");
        obj_cs = 0;

        // Object offset wrap on the second instance
        obj_addr2 = 14'h0020; obj_cs2 = 1;
        n = 0;
        while (!rom_cs2 && n < 20) begin step(); n++; end
        chk("wrap_rom_addr", rom_addr2, 15'h0010);
        rom_ok2 = 1; step(); step(); rom_ok2 = 0;
        chk("wrap_obj_ok", obj_ok2, 1);
        chk("wrap_obj_data", obj_data2, 32'h1234_5678);
        obj_cs2 = 0;
        step();

        // Starvation: S,S,S,S,O,S,S,S,S,O
        scr_addr = 13'h0100; obj_addr = 14'h0200; si = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4)      exp_q.push_back(15'h2200);
            else if (k == 9) exp_q.push_back(15'h2201);
            else begin exp_q.push_back(15'h0100 + 15'(si)); si++; end
        end
        base = issue_cnt;
        scr_cs = 1; obj_cs = 1;
        n = 0;
        while (issue_cnt < base + 10 && n < 300) begin
            step(); n++;
            if (scr_ok) scr_addr = scr_addr + 13'd1;
            if (obj_ok) obj_addr = obj_addr + 14'd1;
        end
        scr_cs = 0;
        n = 0;
        while (!obj_ok && n < 20) begin step(); n++; end
        chk("starve_last_obj_data", obj_data, data_fn(15'h2201));
        obj_cs = 0;
        check_issues("starve_grant");

        // Address change while in WAIT
        step();
        scr_addr = 13'h0001; scr_cs = 1;
        exp_q.push_back(15'h0001); exp_q.push_back(15'h0002);
        base = issue_cnt; n = 0;
        while (issue_cnt == base && n < 20) begin step(); n++; end
        step();
        scr_addr = 13'h0002;
        step();
        chk("midwait_ok_low", scr_ok, 0);
        chk("midwait_first_data", scr_data, data_fn(15'h0001));
        n = 0;
        while (!scr_ok && n < 20) begin step(); n++; end
        chk("midwait_second_data", scr_data, data_fn(15'h0002));
        check_issues("midwait_rom_addr");
        scr_cs = 0;
        step();

        // Reset mid-fetch with a late rom_ok
        model_en = 0;
        scr_addr = 13'h0300; scr_cs = 1;
        exp_q.push_back(15'h0300); exp_q.push_back(15'h0300);
        base = issue_cnt; n = 0;
        while (issue_cnt == base && n < 20) begin step(); n++; end
        step(); step();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("mid_reset_rom_cs", rom_cs, 0);
        chk("mid_reset_busy_addr", {busy, rom_addr}, 0);
        chk("mid_reset_scr", {scr_data | obj_data}, {31'h0, scr_ok | obj_ok});
        scr_cs = 0;
        step();
        rst_n = 1'b1; f_ok = 1;
        base = issue_cnt;
        step(); step();
        f_ok = 0;
        chk("late_ok_ignored_busy", busy, 0);
        chk("late_ok_ignored_data", scr_data, 0);
        chk("late_ok_no_issue", issue_cnt, base);
        model_en = 1;
        scr_cs = 1;
        n = 0;
        while (!scr_ok && n < 20) begin step(); n++; end
        chk("post_reset_data", scr_data, data_fn(15'h0300));
        check_issues("reset_rom_addr");
        scr_cs = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
